// File: rtl/mux_scan_seq.sv
// mux_scan_seq: timed channel scan sequencer for a 4:1 enabled mux.
// Walks enabled channels in ascending order and captures mux output per channel.
module mux_scan_seq #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [3:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_o,
    output logic [1:0]         sel,
    output logic               mux_en,
    output logic               busy,
    output logic               done,
    output logic [3:0]         sample,
    output logic               sample_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_DONE
    } state_t;

    state_t             r_state, w_state;
    logic [1:0]         r_sel, w_sel;
    logic               r_en, w_en;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic [3:0]         r_sample, w_sample;
    logic               r_valid, w_valid;
    logic [DWELL_W-1:0] r_cnt, w_cnt;
    logic [3:0]         r_mask, w_mask;
    logic [DWELL_W-1:0] r_dwell, w_dwell;

    logic [3:0]         w_above;
    logic [3:0]         w_next_bits;

    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Channels strictly above the current select still to be visited
    always_comb begin
        unique case (r_sel)
            2'd0:    w_above = 4'b1110;
            2'd1:    w_above = 4'b1100;
            2'd2:    w_above = 4'b1000;
            default: w_above = 4'b0000;
        endcase
        w_next_bits = r_mask & w_above;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_sel    <= 2'd0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sample <= 4'b0000;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
            r_mask   <= 4'b0000;
            r_dwell  <= '0;
        end else begin
            r_state  <= w_state;
            r_sel    <= w_sel;
            r_en     <= w_en;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_sample <= w_sample;
            r_valid  <= w_valid;
            r_cnt    <= w_cnt;
            r_mask   <= w_mask;
            r_dwell  <= w_dwell;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_sel    = r_sel;
        w_en     = r_en;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_sample = r_sample;
        w_valid  = r_valid;
        w_cnt    = r_cnt;
        w_mask   = r_mask;
        w_dwell  = r_dwell;
        unique case (r_state)
            S_IDLE: begin
                w_en   = 1'b0;
                w_busy = 1'b0;
                if (start) begin
                    w_sample = 4'b0000;
                    if (|ch_mask) begin
                        w_mask  = ch_mask;
                        w_dwell = dwell;
                        w_valid = 1'b0;
                        w_sel   = f_lowest(ch_mask);
                        w_cnt   = dwell;
                        w_en    = 1'b1;
                        w_busy  = 1'b1;
                        w_state = S_DWELL;
                    end else begin
                        w_done  = 1'b1;
                        w_valid = 1'b1;
                        w_state = S_DONE;
                    end
                end
            end
            S_DWELL: begin
                if (stop) begin
                    w_en    = 1'b0;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt = r_cnt - 1'b1;
                end else begin
                    w_sample[r_sel] = mux_o;
                    if (|w_next_bits) begin
                        w_sel = f_lowest(w_next_bits);
                        w_cnt = r_dwell;
                    end else begin
                        w_en    = 1'b0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_valid = 1'b1;
                        w_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
                w_en    = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign sel          = r_sel;
    assign mux_en       = r_en;
    assign busy         = r_busy;
    assign done         = r_done;
    assign sample       = r_sample;
    assign sample_valid = r_valid;

endmodule

// File: tb/tb_mux_scan_seq.sv
// tb_mux_scan_seq: directed bench for mux_scan_seq with a behavioural 4:1 mux.
// Status word per cycle: {sel, mux_en, busy, done, sample_valid, sample}.
module tb_mux_scan_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] ch_mask;
    logic [3:0] dwell;
    logic       mux_o;
    logic [1:0] sel;
    logic       mux_en;
    logic       busy;
    logic       done;
    logic [3:0] sample;
    logic       sample_valid;
    logic [3:0] y;

    int n_run;
    int n_fail;

    mux_scan_seq #(.DWELL_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .ch_mask(ch_mask),
        .dwell(dwell),
        .mux_o(mux_o),
        .sel(sel),
        .mux_en(mux_en),
        .busy(busy),
        .done(done),
        .sample(sample),
        .sample_valid(sample_valid)
    );

    // Behavioural mux4to1En
    assign mux_o = mux_en ? y[sel] : 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] st;
    assign st = {sel, mux_en, busy, done, sample_valid, sample};

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        ch_mask = 4'b0000;
        dwell = 4'd0;
        y = 4'b0000;
        #12;
        n_run++;
        if (st !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", st, 10'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_run++;
        if (st !== 10'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset got=%b exp=%b", st, 10'b0);
        end
    endtask

    task automatic test_full_scan();
        logic [9:0] e [6];
        e[0] = {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
        e[1] = {2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
        e[2] = {2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010};
        e[3] = {2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010};
        e[4] = {2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010};
        e[5] = {2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010};
        y = 4'b1010;
        ch_mask = 4'b1111;
        dwell = 4'd0;
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_run++;
            if (st !== e[k-1]) begin
                n_fail++;
                $display("FAIL full_scan c%0d got=%b exp=%b", k, st, e[k-1]);
            end
            if (k == 1) start = 1'b0;
        end
    endtask

    task automatic test_sparse_dwell();
        logic [9:0] e [8];
        e[0] = {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
        e[1] = e[0];
        e[2] = e[0];
        e[3] = {2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001};
        e[4] = e[3];
        e[5] = e[3];
        e[6] = {2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0101};
        e[7] = {2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0101};
        y = 4'b1111;
        ch_mask = 4'b0101;
        dwell = 4'd2;
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_run++;
            if (st !== e[k-1]) begin
                n_fail++;
                $display("FAIL sparse_dwell c%0d got=%b exp=%b", k, st, e[k-1]);
            end
            if (k == 1) start = 1'b0;
        end
    endtask

    task automatic test_stop();
        logic [9:0] e [10];
        for (int i = 0; i < 4; i++)
            e[i] = {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
        e[4] = {2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001};
        e[5] = e[4];
        for (int i = 6; i < 10; i++)
            e[i] = {2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001};
        y = 4'b1011;
        ch_mask = 4'b1111;
        dwell = 4'd3;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_run++;
            if (st !== e[k-1]) begin
                n_fail++;
                $display("FAIL stop c%0d got=%b exp=%b", k, st, e[k-1]);
            end
            if (k == 1) start = 1'b0;
            if (k == 6) stop = 1'b1;
            if (k == 7) stop = 1'b0;
        end
    endtask

    task automatic test_empty_mask();
        logic [9:0] e [3];
        e[0] = {2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};
        e[1] = {2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
        e[2] = e[1];
        y = 4'b1111;
        ch_mask = 4'b0000;
        dwell = 4'd5;
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_run++;
            if (st !== e[k-1]) begin
                n_fail++;
                $display("FAIL empty_mask c%0d got=%b exp=%b", k, st, e[k-1]);
            end
            if (k == 1) start = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e [6];
        logic [9:0] f [2];
        e[0] = {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
        e[1] = {2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
        e[2] = {2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010};
        e[3] = {2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110};
        e[4] = {2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0110};
        e[5] = {2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110};
        f[0] = {2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
        f[1] = {2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100};
        y = 4'b0110;
        ch_mask = 4'b1111;
        dwell = 4'd0;
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_run++;
            if (st !== e[k-1]) begin
                n_fail++;
                $display("FAIL b2b c%0d got=%b exp=%b", k, st, e[k-1]);
            end
            if (k == 1) begin
                ch_mask = 4'b0001;
                dwell = 4'd5;
            end
            if (k == 3) start = 1'b0;
        end
        ch_mask = 4'b0100;
        dwell = 4'd0;
        start = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            n_run++;
            if (st !== f[k-1]) begin
                n_fail++;
                $display("FAIL restart c%0d got=%b exp=%b", k, st, f[k-1]);
            end
            if (k == 1) start = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] e1;
        logic [9:0] e2;
        y = 4'b1111;
        ch_mask = 4'b1111;
        dwell = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_run++;
        if (st !== 10'b0) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=%b", st, 10'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_run++;
            if (st !== 10'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle c%0d got=%b exp=%b", k, st, 10'b0);
            end
        end
        e1 = {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
        e2 = {2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001};
        ch_mask = 4'b0001;
        dwell = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_run++;
        if (st !== e1) begin
            n_fail++;
            $display("FAIL post_reset_scan c1 got=%b exp=%b", st, e1);
        end
        @(negedge clk);
        n_run++;
        if (st !== e2) begin
            n_fail++;
            $display("FAIL post_reset_scan c2 got=%b exp=%b", st, e2);
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        test_reset();
        test_full_scan();
        test_sparse_dwell();
        test_stop();
        test_empty_mask();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
